ps2_command_tx: RTL
===================

// Module: ps2_command_tx
// PURPOSE
//   PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//   Drives open-drain PS/2 clock/data via active-high pull-low enables; keyboard supplies the bit clock.
//   Sits beside the PS/2 receiver/keyboard_input path. Asserts rx_inhibit during a transfer so the receiver ignores line activity.
// PARAMETERS
//   INHIBIT_CYCLES  6000     clocks ps2_clk held low before request-to-send (>=100us at 50MHz)
//   TIMEOUT_CYCLES  1000000  max clocks between device falling edges (or before first edge) before abort (20ms)
// PORTS
//   clock        in   1  system clock; all logic on posedge
//   reset        in   1  synchronous, active-high
//   cmd_data     in   8  byte to send; sampled when cmd_send accepted
//   cmd_send     in   1  request pulse; accepted only in IDLE
//   cmd_busy     out  1  high from acceptance until DONE/ERROR cycle completes
//   cmd_done     out  1  1-cycle pulse: byte sent and device ACK seen
//   cmd_error    out  1  1-cycle pulse: timeout or missing ACK
//   rx_inhibit   out  1  equals cmd_busy
//   ps2_clk_in   in   1  raw PS/2 clock line (async)
//   ps2_dat_in   in   1  raw PS/2 data line (async)
//   ps2_clk_oe   out  1  1 = pull clock low, 0 = release
//   ps2_dat_oe   out  1  1 = pull data low, 0 = release
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (lines released); counters/shift reg cleared. Reset wins over cmd_send.
//   Reset mid-transfer: lines released next cycle, no done/error pulse.
//   Inputs pass 2-flop synchronizer; fall = sync clk 1->0 (3-cycle latency from pin).
//   Parity bit = ~^cmd_data (odd parity). Bits LSB first.
//   FSM:
//     IDLE    : cmd_send -> latch shift=cmd_data, par; cnt=0; -> INHIBIT. busy=1 next cycle.
//     INHIBIT : clk_oe=1, dat_oe=0; after INHIBIT_CYCLES clocks -> REQ.
//     REQ     : clk_oe=0, dat_oe=1 (start bit 0); timer armed; on fall -> DATA, drive bit0.
//     DATA    : dat_oe = ~shift[0]; each fall shift right, bitcnt++; fall after bit7 -> PARITY.
//     PARITY  : dat_oe = ~par; on fall -> STOP.
//     STOP    : dat_oe=0 (stop=1); on fall -> ACK.
//     ACK     : on fall sample sync data: 0 -> WAITIDLE, 1 -> ERROR.
//     WAITIDLE: wait sync clk=1 and data=1 -> DONE.
//     DONE    : cmd_done=1 one cycle, busy drops same cycle -> IDLE.
//     ERROR   : cmd_error=1 one cycle, lines released, -> IDLE.
//   Timeout: counter cleared on every fall and on REQ entry; reaching TIMEOUT_CYCLES in REQ..WAITIDLE -> ERROR.
//   cmd_send while busy: ignored, no queuing. done and error never both in one cycle.
//   Counters sized $clog2(max(INHIBIT,TIMEOUT)+1); no wrap possible before threshold.
// STRUCTURE
//   ps2_pkg: state enum; constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA, PS2_BREAK=8'hF0.
//   Sub-module ps2_line_sync (2-flop sync + fall detect), instantiated once per line.
//   Top: FSM, shift reg, bit counter, shared inhibit/timeout counter.
// TESTING (bench: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, device model ~10-clock half-period)
//   Send 0xED, model ACKs -> start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; cmd_done once; busy 0 after.
//   Send 0x01 -> parity bit 0 on line; cmd_done; rx_inhibit tracks busy throughout.
//   Model never clocks after inhibit -> cmd_error 200 clocks after REQ entry; clk_oe=dat_oe=0.
//   Model leaves data high in ACK slot -> cmd_error, no cmd_done.
//   reset asserted during DATA bit 4 -> next cycle oe outputs 0, busy 0, no pulses; new send then succeeds.
//   cmd_send with 0x55 while busy sending 0xFF -> ignored; line carries 0xFF only.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side command transmitter.
// Holds the transmitter state encoding, common keyboard command bytes and small helpers.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAITIDLE,
    ST_DONE,
    ST_ERROR
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_BREAK        = 8'hF0;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a registered falling-edge strobe.
// Flops reset to 1 because an idle PS/2 line floats high; this avoids a false fall after reset.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;
  logic fall_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
      fall_reg <= 1'b0;
    end else begin
      meta_reg <= line_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
      fall_reg <= prev_reg & ~sync_reg;
    end
  end

  assign line_sync = sync_reg;
  assign line_fall = fall_reg;

endmodule

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
// The keyboard supplies the bit clock; the host only pulls lines low through the *_oe enables.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic       cmd_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0] line_raw;
  logic [1:0] line_sync;
  logic [1:0] line_fall;

  assign line_raw = {ps2_dat_in, ps2_clk_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      ps2_line_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .line_in   (line_raw[gi]),
        .line_sync (line_sync[gi]),
        .line_fall (line_fall[gi])
      );
    end
  endgenerate

  logic clk_sync;
  logic clk_fall;
  logic dat_sync;
  logic dat_fall_unused;

  assign clk_sync        = line_sync[0];
  assign clk_fall        = line_fall[0];
  assign dat_sync        = line_sync[1];
  assign dat_fall_unused = line_fall[1];

  ps2_tx_state_e    state_reg,   state_next;
  logic [7:0]       shift_reg,   shift_next;
  logic             par_reg,     par_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic             in_timed;

  // States in which the keyboard owes us clock edges and the timeout applies.
  assign in_timed = state_reg inside {ST_REQ, ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAITIDLE};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      bit_cnt_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      bit_cnt_reg <= bit_cnt_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    bit_cnt_next = bit_cnt_reg;
    cnt_next     = cnt_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_send) begin
          state_next   = ST_INHIBIT;
          shift_next   = cmd_data;
          par_next     = odd_parity(cmd_data);
          bit_cnt_next = '0;
        end
      end
      ST_INHIBIT: if (cnt_reg == INHIBIT_LAST) state_next = ST_REQ;
      ST_REQ:     if (clk_fall) state_next = ST_DATA;
      ST_DATA: begin
        if (clk_fall) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
        end
      end
      ST_PARITY:   if (clk_fall) state_next = ST_STOP;
      ST_STOP:     if (clk_fall) state_next = ST_ACK;
      ST_ACK:      if (clk_fall) state_next = dat_sync ? ST_ERROR : ST_WAITIDLE;
      ST_WAITIDLE: if (clk_sync && dat_sync) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      ST_ERROR:    state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase

    // Progress on this cycle takes priority; the timeout only fires on a stalled state.
    if (in_timed && !clk_fall && (state_next == state_reg) && (cnt_reg == TIMEOUT_LAST))
      state_next = ST_ERROR;

    // One counter serves both the inhibit delay and the inter-edge timeout.
    if ((state_reg == ST_IDLE) || (state_next != state_reg) || (in_timed && clk_fall))
      cnt_next = '0;
    else
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_comb begin
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    cmd_done   = 1'b0;
    cmd_error  = 1'b0;
    cmd_busy   = (state_reg != ST_IDLE);

    unique case (state_reg)
      ST_INHIBIT: ps2_clk_oe = 1'b1;
      ST_REQ:     ps2_dat_oe = 1'b1;
      ST_DATA:    ps2_dat_oe = ~shift_reg[0];
      ST_PARITY:  ps2_dat_oe = ~par_reg;
      ST_DONE:    cmd_done   = 1'b1;
      ST_ERROR:   cmd_error  = 1'b1;
      default:    ;
    endcase

    rx_inhibit = cmd_busy;
  end

endmodule
